branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

EX-stage branch resolver and BTB update writer for the pipelined MIPS datapath. Decodes the branch in EX, compares the actual outcome against the prediction carried down from fetch, and drives a same-cycle fetch redirect on mispredict. Queues the resulting BTB corrections in a small FIFO and drains them into the BTB write port through a valid/ready handshake. It is the producer end of the BTB lookup path: BTB contents change only through this block.

## Interface
- QDEPTH, 4, update FIFO entries; power of two, >= 2
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ex_valid  in  1  EX latch holds a real (non-bubble) instruction
- ex_en  in  1  pipeline advances this cycle (PCEN); resolve only when high
- ex_instr  in  32  EX instruction word
- ex_pc_add4  in  32  EX PC+4
- ex_rs_eq  in  1  rs == rt from EX comparator
- ex_pred_taken  in  1  fetch predicted taken (branch_found at IF)
- ex_pred_target  in  32  fetch predicted target (branch_addr at IF)
- redirect  out  1  mispredict; flush IF/ID and load redirect_pc
- redirect_pc  out  32  correct next PC
- upd_valid  out  1  FIFO head valid toward BTB
- upd_ready  in  1  BTB accepts head this cycle
- upd_pc  out  32  branch PC (ex_pc_add4 − 4) of head entry
- upd_target  out  32  taken target of head entry
- upd_taken  out  1  1 = insert/overwrite entry, 0 = invalidate entry
- branch_cnt, mispred_cnt, drop_cnt  out  32 each  statistics (see Configuration)

## Operation
- Branch = ex_valid & ex_en & opcode ∈ {6'h04 BEQ, 6'h05 BNE}; all else ignored, outputs idle.
- actual_taken = BEQ ? ex_rs_eq : ~ex_rs_eq.
- target = ex_pc_add4 + (sign_extend(imm16) << 2), 32-bit modulo (wrap at 2^32 is legal).
- mispredict = (actual_taken ≠ ex_pred_taken) | (actual_taken & ex_pred_taken & ex_pred_target ≠ target).
- On mispredict: redirect=1, redirect_pc = actual_taken ? target : ex_pc_add4; enqueue {pc, target, upd_taken=actual_taken}.
- Correct prediction: no redirect, no enqueue.
- FIFO: circular, QDEPTH entries, log2(QDEPTH)+1-bit read/write pointers; head presented on upd_* while non-empty.
- Dequeue when upd_valid & upd_ready.
- Full and enqueue with no same-cycle dequeue: new entry dropped, drop_cnt++; BTB is a hint, so a drop is functionally safe.
- Full with enqueue and dequeue in the same cycle: both happen; occupancy unchanged, no drop.
- Empty: an enqueue is not visible on upd_valid until the next cycle; no bypass.
- upd_* fields remain stable while upd_valid=1 and upd_ready=0.

## Timing
- redirect/redirect_pc: combinational from EX inputs, same cycle; 0 when no branch is resolving.
- Update latency: enqueue at edge N → upd_valid=1 in cycle N+1 (empty FIFO).
- Throughput: one enqueue and one dequeue per cycle.
- Reset (async, any time, including mid-drain): FIFO emptied, pointers=0, upd_valid=0, upd_pc=upd_target=0, upd_taken=0, all counters=0; redirect=0 while nRST low.
- ex_en=0 (stall): nothing resolves, nothing is counted; the same branch resolves once, when ex_en rises.

## Configuration
- BRANCH_RESOLVE_STATS_EN defined: branch_cnt increments per resolved branch, mispred_cnt per mispredict, drop_cnt per dropped update; all wrap modulo 2^32.
- Not defined: counter registers are not built; all three ports are tied to 32'h0. FIFO, redirect and drop behaviour are identical in both builds.

## Test plan
- BEQ at pc 0x100 (pc_add4 0x104), imm 0x0003, rs_eq=1, pred_taken=0 → redirect=1, redirect_pc=0x110; next cycle upd_valid=1, upd_pc=0x100, upd_target=0x110, upd_taken=1.
- BNE, rs_eq=1, pred_taken=1, pred_target=0x200, pc_add4=0x204 → redirect_pc=0x204; queued entry has upd_taken=0.
- Taken branch predicted correctly with matching target → redirect=0, FIFO stays empty, mispred_cnt unchanged, branch_cnt+1.
- upd_ready=0, five mispredicts with QDEPTH=4 → four entries held in order, drop_cnt=1; then upd_ready=1 → four entries drain in FIFO order over four cycles.
- FIFO full, mispredict with upd_ready=1 in the same cycle → no drop; occupancy stays 4.
- Mispredict held for 3 cycles with ex_en=0, then ex_en=1 → exactly one enqueue and branch_cnt+1; nRST pulsed low with 2 entries queued → upd_valid=0 immediately, counters reset to 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : EX-stage resolver for BEQ/BNE. Compares the real outcome
//               against the fetch prediction, raises a same-cycle redirect
//               on mispredict and queues BTB corrections in a small FIFO that
//               drains to the BTB write port via a valid/ready handshake.
// Optional    : `define BRANCH_RESOLVE_STATS_EN builds the branch, mispredict
//               and drop counters; without it the counter ports read 0.
// Ports       : CLK, nRST (async active-low)
//               ex_*            EX-stage instruction and prediction inputs
//               redirect[_pc]   combinational fetch redirect
//               upd_*           BTB update head (valid/ready)
//               *_cnt           statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int QDEPTH = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic        ex_en,
    input  logic [31:0] ex_instr,
    input  logic [31:0] ex_pc_add4,
    input  logic        ex_rs_eq,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic        upd_taken,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt,
    output logic [31:0] drop_cnt
);

    localparam int AW = $clog2(QDEPTH);
    localparam int PW = AW + 1;

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    // ------------------------------------------------------------------
    // Branch decode and resolution
    // ------------------------------------------------------------------
    logic [5:0]  opcode;
    logic        is_beq;
    logic        is_bne;
    logic        resolving;
    logic        actual_taken;
    logic [31:0] offset;
    logic [31:0] target;
    logic        mispredict;

    assign opcode       = ex_instr[31:26];
    assign is_beq       = (opcode == OP_BEQ);
    assign is_bne       = (opcode == OP_BNE);
    assign resolving    = nRST & ex_valid & ex_en & (is_beq | is_bne);
    assign actual_taken = is_beq ? ex_rs_eq : ~ex_rs_eq;
    assign offset       = {{14{ex_instr[15]}}, ex_instr[15:0], 2'b00};
    assign target       = ex_pc_add4 + offset;

    // A taken/taken pair still mispredicts when fetch jumped to the wrong place.
    assign mispredict = resolving &
                        ((actual_taken != ex_pred_taken) |
                         (actual_taken & ex_pred_taken & (ex_pred_target != target)));

    assign redirect    = mispredict;
    assign redirect_pc = mispredict ? (actual_taken ? target : ex_pc_add4) : 32'h0;

    // Register fields feed only the comparator upstream; not needed here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^ex_instr[25:16];

    // ------------------------------------------------------------------
    // Update FIFO
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          empty;
    logic          full;
    logic          deq;
    logic          push;
    logic          drop;

    logic [31:0] pc_mem  [QDEPTH];
    logic [31:0] tgt_mem [QDEPTH];
    logic        tkn_mem [QDEPTH];

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign deq    = ~empty & upd_ready;
    // A dequeue in the same cycle frees the slot the new entry needs.
    assign push   = mispredict & (~full | deq);
    assign drop   = mispredict & full & ~deq;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (deq)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_idx]  <= ex_pc_add4 - 32'd4;
            tgt_mem[wr_idx] <= target;
            tkn_mem[wr_idx] <= actual_taken;
        end
    end

    assign upd_valid  = ~empty;
    assign upd_pc     = upd_valid ? pc_mem[rd_idx]  : 32'h0;
    assign upd_target = upd_valid ? tgt_mem[rd_idx] : 32'h0;
    assign upd_taken  = upd_valid & tkn_mem[rd_idx];

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] branch_q;
    logic [31:0] mispred_q;
    logic [31:0] drop_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_q  <= 32'h0;
            mispred_q <= 32'h0;
            drop_q    <= 32'h0;
        end else begin
            if (resolving)  branch_q  <= branch_q + 32'd1;
            if (mispredict) mispred_q <= mispred_q + 32'd1;
            if (drop)       drop_q    <= drop_q + 32'd1;
        end
    end

    assign branch_cnt  = branch_q;
    assign mispred_cnt = mispred_q;
    assign drop_cnt    = drop_q;
`else
    logic unused_drop;
    assign unused_drop = drop;

    assign branch_cnt  = 32'h0;
    assign mispred_cnt = 32'h0;
    assign drop_cnt    = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed bench for branch_resolve_unit. Stimulus pushes the
//               expected BTB updates into a queue; a negedge monitor compares
//               the FIFO head against it and pops on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int QDEPTH = 4;
    localparam logic [5:0] BEQ = 6'h04;
    localparam logic [5:0] BNE = 6'h05;

    logic        CLK;
    logic        nRST;
    logic        ex_valid;
    logic        ex_en;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc_add4;
    logic        ex_rs_eq;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;
    logic [31:0] drop_cnt;

    branch_resolve_unit #(.QDEPTH(QDEPTH)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .ex_valid       (ex_valid),
        .ex_en          (ex_en),
        .ex_instr       (ex_instr),
        .ex_pc_add4     (ex_pc_add4),
        .ex_rs_eq       (ex_rs_eq),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt),
        .drop_cnt       (drop_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tkn;
    } ent_t;

    ent_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int exp_branch = 0;
    int exp_mispred = 0;
    int exp_drop = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef BRANCH_RESOLVE_STATS_EN
        chk32({tag, "_branch_cnt"},  branch_cnt,  32'(exp_branch));
        chk32({tag, "_mispred_cnt"}, mispred_cnt, 32'(exp_mispred));
        chk32({tag, "_drop_cnt"},    drop_cnt,    32'(exp_drop));
`else
        chk32({tag, "_branch_cnt"},  branch_cnt,  32'h0);
        chk32({tag, "_mispred_cnt"}, mispred_cnt, 32'h0);
        chk32({tag, "_drop_cnt"},    drop_cnt,    32'h0);
`endif
    endtask

    // Monitor: compares the FIFO head every cycle; pops on each handshake.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk1("upd_valid_idle", upd_valid, 1'b0);
            end else begin
                chk1("upd_valid", upd_valid, 1'b1);
                chk32("upd_pc", upd_pc, exp_q[0].pc);
                chk32("upd_target", upd_target, exp_q[0].tgt);
                chk1("upd_taken", upd_taken, exp_q[0].tkn);
                if (upd_ready) exp_q.delete(0);
            end
        end
    end

    // Called at posedge+1; returns at the following posedge+1.
    task automatic resolve(input logic [5:0] op, input logic [31:0] pa4, input logic [15:0] imm,
                           input logic rs_eq, input logic pt, input logic [31:0] ptgt,
                           input logic valid, input logic en,
                           input logic exp_redir, input logic [31:0] exp_rpc,
                           input logic [31:0] exp_tgt, input logic exp_tkn);
        logic drop;
        ent_t e;
        ex_valid       = valid;
        ex_en          = en;
        ex_instr       = {op, 5'd1, 5'd2, imm};
        ex_pc_add4     = pa4;
        ex_rs_eq       = rs_eq;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
        #2;
        chk1("redirect", redirect, exp_redir);
        if (exp_redir) chk32("redirect_pc", redirect_pc, exp_rpc);
        if (valid && en && (op == BEQ || op == BNE)) exp_branch++;
        drop = 1'b0;
        if (exp_redir) begin
            exp_mispred++;
            drop = (exp_q.size() == QDEPTH) && !upd_ready;
            if (drop) exp_drop++;
        end
        @(posedge CLK);
        #1;
        if (exp_redir && !drop) begin
            e.pc  = pa4 - 32'd4;
            e.tgt = exp_tgt;
            e.tkn = exp_tkn;
            exp_q.push_back(e);
        end
        ex_valid = 1'b0;
        ex_en    = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ex_valid = 1'b0;
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        nRST = 1'b0;
        ex_valid = 1'b0; ex_en = 1'b1; ex_instr = 32'h0; ex_pc_add4 = 32'h0;
        ex_rs_eq = 1'b0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        upd_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk1("rst_upd_valid", upd_valid, 1'b0);
        chk32("rst_upd_pc", upd_pc, 32'h0);
        chk32("rst_upd_target", upd_target, 32'h0);
        chk1("rst_redirect", redirect, 1'b0);
        check_cnt("rst");
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // BEQ taken, predicted not-taken
        resolve(BEQ, 32'h104, 16'h0003, 1, 0, 32'h0, 1, 1, 1, 32'h110, 32'h110, 1);
        idle(1);
        // BNE not taken, predicted taken
        resolve(BNE, 32'h204, 16'hFFFF, 1, 1, 32'h200, 1, 1, 1, 32'h204, 32'h200, 0);
        idle(1);
        check_cnt("t2");
        // Correct taken prediction with matching target
        resolve(BEQ, 32'h304, 16'h0010, 1, 1, 32'h344, 1, 1, 0, 32'h0, 32'h344, 1);
        check_cnt("correct");
        // Taken/taken, wrong target; negative offset wraps below zero page
        resolve(BEQ, 32'h404, 16'h8000, 1, 1, 32'h500, 1, 1, 1, 32'hFFFE0404, 32'hFFFE0404, 1);
        // Non-branch opcode and bubble are ignored
        resolve(6'h23, 32'h504, 16'h0004, 1, 0, 32'h0, 1, 1, 0, 32'h0, 32'h0, 0);
        resolve(BEQ, 32'h604, 16'h0004, 1, 0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 0);
        idle(2);
        check_cnt("t5");

        // Back-pressure: five mispredicts into a four-entry FIFO
        upd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            resolve(BNE, 32'h1004 + 32'(k * 16), 16'h0001, 0, 0, 32'h0, 1, 1,
                    1, 32'h1008 + 32'(k * 16), 32'h1008 + 32'(k * 16), 1);
        end
        chk32("held_head_pc", upd_pc, 32'h1000);
        check_cnt("overflow");
        // Full, enqueue with same-cycle dequeue: no drop
        upd_ready = 1'b1;
        resolve(BNE, 32'h2004, 16'h0001, 0, 0, 32'h0, 1, 1, 1, 32'h2008, 32'h2008, 1);
        upd_ready = 1'b0;
        idle(1);
        chk1("full_valid", upd_valid, 1'b1);
        chk32("full_head_pc", upd_pc, 32'h1010);
        check_cnt("full_deq");
        upd_ready = 1'b1;
        idle(5);
        chk1("drained", upd_valid, 1'b0);

        // Stall: three cycles with ex_en low, then resolve once
        for (int k = 0; k < 3; k++) begin
            resolve(BEQ, 32'h3004, 16'h0002, 1, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0, 0);
            ex_en = 1'b0;
        end
        resolve(BEQ, 32'h3004, 16'h0002, 1, 0, 32'h0, 1, 1, 1, 32'h300C, 32'h300C, 1);
        idle(2);
        check_cnt("stall");

        // Reset with two entries queued, mispredict on the EX inputs
        upd_ready = 1'b0;
        resolve(BEQ, 32'h4004, 16'h0001, 1, 0, 32'h0, 1, 1, 1, 32'h4008, 32'h4008, 1);
        resolve(BEQ, 32'h4104, 16'h0001, 1, 0, 32'h0, 1, 1, 1, 32'h4108, 32'h4108, 1);
        ex_valid = 1'b1; ex_en = 1'b1;
        ex_instr = {BEQ, 5'd1, 5'd2, 16'h0001}; ex_pc_add4 = 32'h4204;
        ex_rs_eq = 1'b1; ex_pred_taken = 1'b0;
        nRST = 1'b0;
        exp_q.delete();
        exp_branch = 0; exp_mispred = 0; exp_drop = 0;
        #1;
        chk1("arst_upd_valid", upd_valid, 1'b0);
        chk32("arst_upd_pc", upd_pc, 32'h0);
        chk32("arst_upd_target", upd_target, 32'h0);
        chk1("arst_upd_taken", upd_taken, 1'b0);
        chk1("arst_redirect", redirect, 1'b0);
        check_cnt("arst");
        ex_valid = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        upd_ready = 1'b1;
        idle(2);
        chk1("post_rst_valid", upd_valid, 1'b0);
        check_cnt("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
